// File: rtl/crc_sequencer_pkg.sv
// Shared sizes, FSM encoding, latched-configuration payload and bit helpers
// for the bit-serial CRC sequencer.
package crc_sequencer_pkg;

    localparam int unsigned MAX_BITS       = 32;
    localparam int unsigned MAX_BYTES      = MAX_BITS / 8;
    localparam int unsigned MAX_BYTE_WIDTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic [MAX_BYTE_WIDTH-1:0] bytewidth;
        logic [MAX_BITS-1:0]       poly;
        logic [MAX_BITS-1:0]       xorout;
        logic                      refin;
        logic                      refout;
    } crc_cfg_t;

    // All-ones in bits W-1:0 where W = 8*(bw+1); shift by 8*(MAX_BYTES-1-bw).
    function automatic logic [MAX_BITS-1:0] width_mask(input logic [MAX_BYTE_WIDTH-1:0] bw);
        return {MAX_BITS{1'b1}} >> {~bw, 3'b000};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

endpackage

// File: rtl/crc_sequencer_reflect8n.sv
// Reflects the low 8*(bytewidth+1) bits of a word: byte order is reversed and
// every byte is bit-reversed; bytes above the active width read as zero.
module crc_sequencer_reflect8n
    import crc_sequencer_pkg::*;
(
    input  logic [MAX_BITS-1:0]       data_i,
    input  logic [MAX_BYTE_WIDTH-1:0] bytewidth_i,
    output logic [MAX_BITS-1:0]       data_o
);

    logic [MAX_BYTES-1:0][7:0] in_b;
    logic [MAX_BYTES-1:0][7:0] out_b;

    assign in_b   = data_i;
    assign data_o = out_b;

    for (genvar k = 0; k < MAX_BYTES; k++) begin : g_byte
        logic [MAX_BYTE_WIDTH-1:0] src;
        assign src      = bytewidth_i - MAX_BYTE_WIDTH'(k);
        assign out_b[k] = (MAX_BYTE_WIDTH'(k) <= bytewidth_i) ? rev8(in_b[src]) : 8'h00;
    end

endmodule

// File: rtl/crc_sequencer.sv
// Bit-serial CRC engine controller: latch config, take bytes over valid/ready,
// shift one bit per clock, then reflect/XOR and hold the result until consumed.
module crc_sequencer
    import crc_sequencer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [MAX_BYTE_WIDTH-1:0] cfg_bytewidth,
    input  logic [MAX_BITS-1:0]       cfg_poly,
    input  logic [MAX_BITS-1:0]       cfg_init,
    input  logic [MAX_BITS-1:0]       cfg_xorout,
    input  logic                      cfg_refin,
    input  logic                      cfg_refout,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX_BITS-1:0]       out_crc,
    output logic                      busy
);

    state_e              state_q, state_d;
    crc_cfg_t            cfg_q;
    logic [MAX_BITS-1:0] crc_q;
    logic [7:0]          byte_q;
    logic [2:0]          bitcnt_q;
    logic                last_q;
    logic [MAX_BITS-1:0] out_crc_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [MAX_BITS-1:0] mask_w;
    logic                fb;
    logic [MAX_BITS-1:0] crc_shift_d;
    logic [MAX_BITS-1:0] crc_rev;
    logic [MAX_BITS-1:0] crc_final_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_crc   = out_crc_q;
    assign busy      = busy_q;

    crc_sequencer_reflect8n u_reflect (
        .data_i      (crc_q),
        .bytewidth_i (cfg_q.bytewidth),
        .data_o      (crc_rev)
    );

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACCEPT;
            ST_ACCEPT: if (in_valid && in_ready_q) state_d = ST_SHIFT;
            ST_SHIFT:  if (bitcnt_q == 3'd7) state_d = last_q ? ST_FINAL : ST_ACCEPT;
            ST_FINAL:  state_d = ST_DONE;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // One MSB-first polynomial step; register top bit sits at W-1 for every width
    always_comb begin
        mask_w      = width_mask(cfg_q.bytewidth);
        fb          = crc_q[{cfg_q.bytewidth, 3'b111}] ^ byte_q[7];
        crc_shift_d = ((crc_q << 1) ^ (fb ? cfg_q.poly : '0)) & mask_w;
        crc_final_d = ((cfg_q.refout ? crc_rev : crc_q) ^ cfg_q.xorout) & mask_w;
    end

    // Flag outputs are registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            crc_q       <= '0;
            byte_q      <= '0;
            bitcnt_q    <= '0;
            last_q      <= 1'b0;
            out_crc_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_ACCEPT);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cfg_q.bytewidth <= cfg_bytewidth;
                        cfg_q.poly      <= cfg_poly;
                        cfg_q.xorout    <= cfg_xorout;
                        cfg_q.refin     <= cfg_refin;
                        cfg_q.refout    <= cfg_refout;
                        crc_q           <= cfg_init & width_mask(cfg_bytewidth);
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid && in_ready_q) begin
                        byte_q   <= cfg_q.refin ? rev8(in_data) : in_data;
                        last_q   <= in_last;
                        bitcnt_q <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    crc_q    <= crc_shift_d;
                    byte_q   <= byte_q << 1;
                    bitcnt_q <= bitcnt_q + 3'd1;
                end
                ST_FINAL: begin
                    out_crc_q <= crc_final_d;
                end
                default: ;
            endcase
        end
    end

endmodule
